// File: rtl/beat_pkg.sv
// Shared defaults for the tempo/beat generator and the beat-counter width helper.
package beat_pkg;
  localparam int TICK_DIV_DEF  = 10;
  localparam int BEAT_UNIT_DEF = 16;
  localparam int LED_TICKS_DEF = 8;

  // The beat counter must hold up to 8*BEAT_UNIT-1 ticks (slowest tempo).
  function automatic int cnt_w(input int beat_unit);
    return $clog2(8 * beat_unit);
  endfunction

  localparam int CNT_W_DEF = cnt_w(BEAT_UNIT_DEF);
endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module tick_prescaler
  import beat_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset)             r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);
endmodule

// File: rtl/top.sv
// Tempo generator: beat period BEAT_UNIT*(8-S) ticks, one-cycle pulse per beat,
// LED held for LED_TICKS ticks after each pulse.
module top
  import beat_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int BEAT_UNIT = BEAT_UNIT_DEF,
  parameter int LED_TICKS = LED_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] S,
  output logic       pulse,
  output logic       led
);
  localparam int CNT_W = cnt_w(BEAT_UNIT);
  localparam int LW    = (LED_TICKS > 1) ? $clog2(LED_TICKS) : 1;
  localparam logic [LW-1:0] LED_LAST = LW'(LED_TICKS - 1);

  logic             w_tick;
  logic             w_beat_end;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] r_beat;
  logic [2:0]       r_s_lat;
  logic             r_first;
  logic [LW-1:0]    r_led_cnt;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_last     = CNT_W'(BEAT_UNIT * (8 - int'(r_s_lat)) - 1);
  assign w_beat_end = w_tick && (r_beat == w_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_beat    <= '0;
      r_s_lat   <= 3'b111;
      r_first   <= 1'b1;
      r_led_cnt <= '0;
      pulse     <= 1'b0;
      led       <= 1'b0;
    end else begin
      r_first <= 1'b0;
      pulse   <= w_beat_end;
      if (w_tick) r_beat <= w_beat_end ? '0 : r_beat + 1'b1;
      // Tempo only changes at beat boundaries so the running beat keeps its length.
      if (r_first || w_beat_end) r_s_lat <= S;
      if (w_beat_end) begin
        led       <= 1'b1;
        r_led_cnt <= '0;
      end else if (led && w_tick) begin
        if (r_led_cnt == LED_LAST) led <= 1'b0;
        else                       r_led_cnt <= r_led_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_top.sv
// Directed bench for the tempo generator; cycle c = c-th rising edge after reset release.
module tb_top;
  localparam int LED_WIN = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] S;
  logic       pulse, led;

  int checks = 0;
  int fails  = 0;
  int exp_q[$];

  top dut (.clk(clk), .reset(reset), .S(S), .pulse(pulse), .led(led));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input string tag, input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk({tag, "_pulse"}, int'(pulse), 0);
      chk({tag, "_led"}, int'(led), 0);
    end
    reset = 1'b1;
  endtask

  // Runs n cycles after release, comparing pulse/led every cycle against exp_q.
  task automatic run(input string tag, input int n, input int chg_at, input logic [2:0] s_new);
    int np = 0, perr = 0, lerr = 0, dbl = 0, first = -1;
    bit ep, el, prev = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      ep = 1'b0; el = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i] == c) ep = 1'b1;
        if (c >= exp_q[i] && c < exp_q[i] + LED_WIN) el = 1'b1;
      end
      if (pulse === 1'b1) begin
        np++;
        if (first < 0) first = c;
      end
      if (pulse !== ep) perr++;
      if (led !== el) lerr++;
      if (pulse === 1'b1 && prev) dbl++;
      prev = (pulse === 1'b1);
      if (c == chg_at) S = s_new;
    end
    chk({tag, "_npulse"}, np, exp_q.size());
    chk({tag, "_first"}, first, (exp_q.size() > 0) ? exp_q[0] : -1);
    chk({tag, "_pulse_cyc_err"}, perr, 0);
    chk({tag, "_led_cyc_err"}, lerr, 0);
    chk({tag, "_back2back"}, dbl, 0);
  endtask

  initial begin
    reset = 1'b0;
    S     = 3'b111;

    apply_reset("rst0", 3);
    exp_q = '{160, 320, 480};
    run("s7", 500, 0, 3'b111);

    S = 3'b000;
    apply_reset("rst1", 3);
    exp_q = '{1280};
    run("s0", 2000, 0, 3'b000);

    S = 3'b111;
    apply_reset("rst2", 3);
    exp_q = '{160, 480, 800};
    run("s7to6", 900, 100, 3'b110);

    S = 3'b100;
    apply_reset("rst3", 3);
    exp_q = '{640, 1280, 1920};
    run("s4", 2000, 0, 3'b100);

    S = 3'b111;
    apply_reset("rst4", 3);
    exp_q = '{160};
    run("pre_abort", 200, 0, 3'b111);
    apply_reset("abort", 5);
    exp_q = '{160, 320};
    run("post_abort", 400, 0, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter TICK_DIV, default 10: clock cycles per tick (prescaler ratio, >=2).
REQ-002 Parameter BEAT_UNIT, default 16: ticks per tempo step.
REQ-003 Parameter LED_TICKS, default 8: LED on-time in ticks; SHALL be < BEAT_UNIT.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset is synchronous and active-low.
REQ-006 S  input  3  tempo select; 3'b111 is fastest, 3'b000 is slowest.
REQ-007 pulse  output  1  registered one-cycle beat strobe.
REQ-008 led  output  1  registered beat indicator, high for a fixed window after each beat.

Function
REQ-009 The prescaler SHALL count 0..TICK_DIV-1 and wrap, producing a one-cycle internal tick when the count equals TICK_DIV-1.
REQ-010 Beat period SHALL be P_ticks = BEAT_UNIT*(8-S_lat) ticks, i.e. P = TICK_DIV*BEAT_UNIT*(8-S_lat) cycles; with defaults this is 160 cycles (S=7) through 1280 cycles (S=0).
REQ-011 S_lat SHALL be a register loaded from S on the first cycle after reset release and at every beat boundary, never mid-beat.
REQ-012 A change of S mid-beat SHALL have no effect on the beat in progress; the new period SHALL apply from the next beat.
REQ-013 The beat counter SHALL advance only on ticks, wrap to 0 when it reaches P_ticks-1 on a tick, and never exceed 8*BEAT_UNIT-1; its width SHALL be ceil(log2(8*BEAT_UNIT)) bits.
REQ-014 pulse SHALL be high for exactly one cycle per beat, first after the P-th rising edge following reset release, then every P cycles.
REQ-015 pulse SHALL never be high on two consecutive cycles.
REQ-016 led SHALL go high in the same cycle as pulse and stay high for exactly LED_TICKS*TICK_DIV cycles (80 with defaults), then low until the next pulse.
REQ-017 led SHALL be low between the end of its window and the next pulse for every S, because LED_TICKS < BEAT_UNIT.
REQ-018 S SHALL be treated as unsigned and all 8 codes SHALL be legal; no other tempo table exists.

Reset
REQ-019 While reset is low at a rising edge: prescaler, beat counter and LED timer SHALL clear to 0, pulse SHALL be 0, led SHALL be 0, and S_lat SHALL load 3'b111.
REQ-020 Asserting reset mid-beat SHALL abort the beat with outputs 0 on the following cycle; after release, timing SHALL restart per REQ-014 as if from power-up.

Structure
REQ-021 A shared package SHALL hold TICK_DIV, BEAT_UNIT and LED_TICKS defaults, plus the counter-width constant.
REQ-022 A single sub-module, tick_prescaler (clk, reset, tick output), SHALL implement REQ-009; the beat counter, S_lat, pulse and LED timer SHALL live in top.

Verification
REQ-023 Hold reset low 3 cycles with S=3'b111 -> pulse=0 and led=0 throughout.
REQ-024 Release reset, S=3'b111 -> pulse after edge 160, 320, 480 (+/-0); led high for 80 cycles starting with each pulse.
REQ-025 S=3'b000 held 2000 cycles after reset -> exactly one pulse, at cycle 1280; led high cycles 1280-1359 only.
REQ-026 S=3'b111, change to 3'b110 at cycle 100 -> pulse at 160 (old period), then 480, 800 (period 320).
REQ-027 S=3'b100 held 2000 cycles -> exactly 3 pulses, spaced 640 cycles apart.
REQ-028 Assert reset at cycle 200 (mid-led window with S=3'b111), release at 205 -> pulse/led 0 from cycle 201; next pulse 160 edges after release.
